// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the 24-bit CPU datapath.
// Steps fetch/decode/execute/memory/writeback per opcode, with a memory-wait timeout and retire counter.
module multicycle_control_fsm #(
  parameter int CNT_W       = 24,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic [3:0]       Opcode,
  input  logic             Stall,
  input  logic             MemReady,
  output logic             PcWrite,
  output logic             PcWriteCond,
  output logic [1:0]       PcSrc,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IrWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [1:0]       AluOp,
  output logic             Illegal,
  output logic             BusError,
  output logic [CNT_W-1:0] InstrCount,
  output logic [3:0]       State
);

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_WB_ALU = 4'd4,
    ST_ADDR   = 4'd5,
    ST_MEM    = 4'd6,
    ST_WB_MEM = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_J    = 4'b0101;

  // Timeout fires in the cycle where this one would make the count reach MEM_TIMEOUT.
  localparam logic [7:0] WAIT_LIM = 8'(MEM_TIMEOUT - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       op_r;
  logic [7:0]       wait_r;
  logic [7:0]       wait_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic             mem_req_s;
  logic             timeout_s;
  logic             retire_s;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: is_legal = 1'b1;
      default:                                   is_legal = 1'b0;
    endcase
  endfunction

  // Memory request, timeout and retire qualifiers shared by the other processes.
  always_comb begin
    mem_req_s = 1'b0;
    retire_s  = 1'b0;
    case (state_r)
      ST_FETCH:  mem_req_s = !Stall;
      ST_MEM:    begin
        mem_req_s = 1'b1;
        retire_s  = MemReady && (op_r == OP_SW);
      end
      ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: retire_s = 1'b1;
      default:   mem_req_s = 1'b0;
    endcase
    timeout_s = mem_req_s && !MemReady && (wait_r >= WAIT_LIM);
    if (mem_req_s && !MemReady && !timeout_s) begin
      wait_nxt_s = wait_r + 8'd1;
    end else begin
      wait_nxt_s = 8'd0;
    end
  end

  // State, latched opcode, wait counter and retire counter.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_r <= ST_RST;
      op_r    <= 4'd0;
      wait_r  <= 8'd0;
      count_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      wait_r  <= wait_nxt_s;
      if (state_r == ST_DECODE) begin
        op_r <= Opcode;
      end else begin
        op_r <= op_r;
      end
      if (retire_s) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RST:    state_nxt_s = ST_FETCH;
      ST_FETCH: begin
        if (Stall) begin
          state_nxt_s = ST_FETCH;
        end else if (MemReady) begin
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (Opcode)
          OP_R, OP_ADDI: state_nxt_s = ST_EXEC;
          OP_LW, OP_SW:  state_nxt_s = ST_ADDR;
          OP_BEQ:        state_nxt_s = ST_BRANCH;
          OP_J:          state_nxt_s = ST_JUMP;
          default:       state_nxt_s = ST_FETCH;
        endcase
      end
      ST_EXEC:   state_nxt_s = ST_WB_ALU;
      ST_WB_ALU: state_nxt_s = ST_FETCH;
      ST_ADDR:   state_nxt_s = ST_MEM;
      ST_MEM: begin
        if (MemReady) begin
          state_nxt_s = (op_r == OP_LW) ? ST_WB_MEM : ST_FETCH;
        end else if (timeout_s) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WB_MEM: state_nxt_s = ST_FETCH;
      ST_BRANCH: state_nxt_s = ST_FETCH;
      ST_JUMP:   state_nxt_s = ST_FETCH;
      default:   state_nxt_s = ST_RST;
    endcase
  end

  // Datapath control decode from state and latched opcode.
  always_comb begin
    PcWrite     = 1'b0;
    PcWriteCond = 1'b0;
    PcSrc       = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IrWrite     = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    AluOp       = 2'b00;
    Illegal     = 1'b0;
    BusError    = timeout_s;
    case (state_r)
      ST_FETCH: begin
        if (!Stall) begin
          MemRead = 1'b1;
          AluSrcB = 2'b01;
          IrWrite = MemReady;
          PcWrite = MemReady;
        end else begin
          MemRead = 1'b0;
        end
      end
      ST_DECODE: begin
        AluSrcB = 2'b11;
        Illegal = !is_legal(Opcode);
      end
      ST_EXEC: begin
        AluSrcA = 1'b1;
        if (op_r == OP_R) begin
          AluSrcB = 2'b00;
          AluOp   = 2'b10;
        end else begin
          AluSrcB = 2'b10;
          AluOp   = 2'b00;
        end
      end
      ST_WB_ALU: begin
        RegWrite = 1'b1;
        RegDst   = (op_r == OP_R);
      end
      ST_ADDR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
      end
      ST_MEM: begin
        IorD     = 1'b1;
        MemRead  = (op_r == OP_LW);
        MemWrite = (op_r == OP_SW);
      end
      ST_WB_MEM: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      ST_BRANCH: begin
        AluSrcA     = 1'b1;
        AluOp       = 2'b01;
        PcWriteCond = 1'b1;
        PcSrc       = 2'b01;
      end
      ST_JUMP: begin
        PcWrite = 1'b1;
        PcSrc   = 2'b10;
      end
      default: begin
        PcWrite = 1'b0;
      end
    endcase
  end

  assign InstrCount = count_r;
  assign State      = state_r;

endmodule
